verificar_disparo: RTL and testbench



---
 rtl/verificar_disparo.sv | 117 +++++++++++
 tb/tb_verificar_disparo.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/verificar_disparo.sv
// verificar_disparo: checks a shot against five stored ship cells and tracks sunk ships, fired cells, shot count and game over.
module verificar_disparo #(
    parameter int NUM_CELLS = 25,
    parameter int SHOT_MAX  = 63
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_game,
    input  logic [4:0] barco1,
    input  logic [4:0] barco2,
    input  logic [4:0] barco3,
    input  logic [4:0] barco4,
    input  logic [4:0] barco5,
    input  logic       shot_valid,
    input  logic [4:0] shot_pos,
    output logic       shot_ready,
    output logic       result_valid,
    input  logic       result_ready,
    output logic       result_hit,
    output logic       result_repeat,
    output logic       result_invalid,
    output logic [2:0] result_ship,
    output logic [4:0] sunk_mask,
    output logic [5:0] shot_count,
    output logic       game_over
);
    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;
    state_t state, state_nxt;
    logic [2:0] idx, first;
    logic [4:0] pos, match, placed, sunk_nxt, scan_cell;
    logic [4:0][4:0] snap;
    logic [NUM_CELLS-1:0] fired, pos_oh;
    logic accept, resolve, scan_hit, invalid, repeated, legal;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nxt;
    always_comb begin
        state_nxt = state;
        if (new_game) state_nxt = IDLE;
        else if (state == IDLE) state_nxt = accept ? SCAN : IDLE;
        else if (state == SCAN) state_nxt = resolve ? REPORT : SCAN;
        else if (state == REPORT) state_nxt = result_ready ? IDLE : REPORT;
    end
    always_comb shot_ready = (state == IDLE) && !game_over;
    // idx runs 1..5 over the ships; idx 6 is the resolving cycle that enters REPORT
    always_comb begin
        accept    = shot_valid && shot_ready;
        resolve   = (state == SCAN) && (idx == 3'd6);
        scan_cell = (idx >= 3'd1 && idx <= 3'd5) ? snap[idx - 3'd1] : 5'd0;
        scan_hit  = (state == SCAN) && (scan_cell != 5'd0) && (scan_cell == pos);
        invalid   = (pos == 5'd0) || (pos > 5'(NUM_CELLS));
        pos_oh    = invalid ? '0 : (NUM_CELLS'(1) << (pos - 5'd1));
        repeated  = |(fired & pos_oh);
        legal     = !invalid && !repeated;
        sunk_nxt  = legal ? (sunk_mask | match) : sunk_mask;
        for (int i = 0; i < 5; i++) placed[i] = |snap[i];
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            idx <= '0;
            first <= '0;
            pos <= '0;
            match <= '0;
            snap <= '0;
            fired <= '0;
            sunk_mask <= '0;
            shot_count <= '0;
            game_over <= 1'b0;
            result_valid <= 1'b0;
            result_hit <= 1'b0;
            result_repeat <= 1'b0;
            result_invalid <= 1'b0;
            result_ship <= '0;
        end else if (new_game) begin
            idx <= '0;
            first <= '0;
            pos <= '0;
            match <= '0;
            snap <= '0;
            fired <= '0;
            sunk_mask <= '0;
            shot_count <= '0;
            game_over <= 1'b0;
            result_valid <= 1'b0;
            result_hit <= 1'b0;
            result_repeat <= 1'b0;
            result_invalid <= 1'b0;
            result_ship <= '0;
        end else begin
            if (state == IDLE && accept) begin
                pos <= shot_pos;
                snap <= {barco5, barco4, barco3, barco2, barco1};
                match <= '0;
                first <= '0;
                idx <= 3'd1;
            end
            if (state == SCAN && !resolve) begin
                idx <= idx + 3'd1;
                if (scan_hit) match[idx - 3'd1] <= 1'b1;
                if (scan_hit && first == 3'd0) first <= idx;
            end
            if (resolve) begin
                result_valid <= 1'b1;
                result_invalid <= invalid;
                result_repeat <= !invalid && repeated;
                result_hit <= legal && |match;
                result_ship <= legal ? first : 3'd0;
                sunk_mask <= sunk_nxt;
                game_over <= game_over || (placed != 5'd0 && (sunk_nxt & placed) == placed);
                if (legal) begin
                    fired <= fired | pos_oh;
                    shot_count <= (shot_count == 6'(SHOT_MAX)) ? shot_count : shot_count + 6'd1;
                end
            end
            if (state == REPORT && result_ready) result_valid <= 1'b0;
        end
endmodule

// File: tb/tb_verificar_disparo.sv
// tb_verificar_disparo: directed shots with hand-computed expectations for verificar_disparo.
module tb_verificar_disparo;
    logic clk = 0, rst = 1, new_game = 0;
    logic [4:0] barco1 = 0, barco2 = 0, barco3 = 0, barco4 = 0, barco5 = 0;
    logic shot_valid = 0, result_ready = 1;
    logic [4:0] shot_pos = 0;
    logic shot_ready, result_valid, result_hit, result_repeat, result_invalid, game_over;
    logic [2:0] result_ship;
    logic [4:0] sunk_mask;
    logic [5:0] shot_count;
    int total = 0, passed = 0;
    always #5 clk = ~clk;
    verificar_disparo dut (
        .clk(clk), .rst(rst), .new_game(new_game),
        .barco1(barco1), .barco2(barco2), .barco3(barco3), .barco4(barco4), .barco5(barco5),
        .shot_valid(shot_valid), .shot_pos(shot_pos), .shot_ready(shot_ready),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_hit(result_hit), .result_repeat(result_repeat), .result_invalid(result_invalid),
        .result_ship(result_ship), .sunk_mask(sunk_mask), .shot_count(shot_count), .game_over(game_over)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    task automatic do_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
    endtask
    // waits for shot_ready, fires one shot and measures accept-to-result latency
    task automatic shoot(input logic [4:0] p);
        int n;
        @(negedge clk);
        n = 0;
        while (!shot_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready", shot_ready, 1);
        shot_pos = p;
        shot_valid = 1;
        @(posedge clk);
        #1 shot_valid = 0;
        n = 0;
        while (!result_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", n, 6);
    endtask
    task automatic res(input string tag, input logic h, input logic r, input logic i, input logic [2:0] s,
                       input logic [4:0] sm, input logic [5:0] c);
        chk({tag, "_hit"}, result_hit, h);
        chk({tag, "_rep"}, result_repeat, r);
        chk({tag, "_inv"}, result_invalid, i);
        chk({tag, "_ship"}, result_ship, s);
        chk({tag, "_sunk"}, sunk_mask, sm);
        chk({tag, "_cnt"}, shot_count, c);
    endtask
    initial begin
        logic seen;
        {barco1, barco2, barco3, barco4, barco5} = {5'd3, 5'd7, 5'd12, 5'd18, 5'd25};
        do_reset();
        chk("rst_ready", shot_ready, 1);
        chk("rst_valid", result_valid, 0);
        chk("rst_cnt", shot_count, 0);
        chk("rst_sunk", sunk_mask, 0);
        chk("rst_go", game_over, 0);
        shoot(7);
        res("hit", 1, 0, 0, 3'd2, 5'b00010, 1);
        chk("hit_go", game_over, 0);
        do_reset();
        shoot(4);
        res("miss", 0, 0, 0, 3'd0, 5'b00000, 1);
        shoot(4);
        res("repeat", 0, 1, 0, 3'd0, 5'b00000, 1);
        shoot(3);
        res("after_rep", 1, 0, 0, 3'd1, 5'b00001, 2);
        do_reset();
        shoot(0);
        res("inv0", 0, 0, 1, 3'd0, 5'b00000, 0);
        shoot(26);
        res("inv26", 0, 0, 1, 3'd0, 5'b00000, 0);
        barco5 = 0;
        do_reset();
        shoot(3);
        shoot(7);
        shoot(12);
        chk("go_early", game_over, 0);
        shoot(18);
        res("go", 1, 0, 0, 3'd4, 5'b01111, 4);
        chk("go_set", game_over, 1);
        @(posedge clk);
        #1 chk("go_ready", shot_ready, 0);
        @(negedge clk);
        shot_pos = 25;
        shot_valid = 1;
        seen = 0;
        repeat (10) begin
            @(posedge clk);
            #1 if (result_valid) seen = 1;
        end
        shot_valid = 0;
        chk("go_ignored", seen, 0);
        chk("go_cnt", shot_count, 4);
        {barco1, barco2, barco3, barco4, barco5} = {5'd3, 5'd9, 5'd12, 5'd9, 5'd25};
        do_reset();
        result_ready = 0;
        shoot(9);
        barco2 = 5'd1;
        res("dup", 1, 0, 0, 3'd2, 5'b01010, 1);
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("bp_valid", result_valid, 1);
            chk("bp_ship", result_ship, 2);
            chk("bp_hit", result_hit, 1);
        end
        chk("bp_ready", shot_ready, 0);
        @(negedge clk);
        result_ready = 1;
        @(posedge clk);
        #1;
        chk("bp_drop", result_valid, 0);
        chk("bp_idle", shot_ready, 1);
        barco2 = 5'd9;
        do_reset();
        shoot(3);
        @(negedge clk);
        shot_pos = 12;
        shot_valid = 1;
        @(posedge clk);
        #1 shot_valid = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        new_game = 1;
        @(posedge clk);
        #1 new_game = 0;
        chk("abort_cnt", shot_count, 0);
        chk("abort_sunk", sunk_mask, 0);
        chk("abort_ready", shot_ready, 1);
        seen = 0;
        repeat (10) begin
            @(posedge clk);
            #1 if (result_valid) seen = 1;
        end
        chk("abort_noresult", seen, 0);
        result_ready = 0;
        shoot(9);
        res("pre_rst", 1, 0, 0, 3'd2, 5'b01010, 1);
        #2 rst = 1;
        #1;
        chk("arst_valid", result_valid, 0);
        chk("arst_hit", result_hit, 0);
        chk("arst_sunk", sunk_mask, 0);
        chk("arst_cnt", shot_count, 0);
        @(negedge clk);
        rst = 0;
        #1 chk("arst_ready", shot_ready, 1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
